// File: rtl/shift_mul_seq.sv
// Sequential unsigned shift-and-add multiplier, one iteration per clock, start/busy/done handshake.
// Optional SHIFT_MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
module shift_mul_seq #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   // state | meaning
   // IDLE  | waiting for start
   // RUN   | one shift/accumulate iteration per clock
   // DONE  | product valid, done pulse; start here is accepted back-to-back

   localparam int PW = 2 * WIDTH;
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [PW-1:0]     mcand;
   logic [PW-1:0]     acc;
   logic [PW-1:0]     acc_sum;
   logic [WIDTH-1:0]  mplr;
   logic [WIDTH-1:0]  mplr_shr;
   logic [CW-1:0]     cnt;
   logic              last_iter;
   logic              load;

   always_comb begin
      acc_sum  = acc + (mplr[0] ? mcand : {PW{1'b0}});
      mplr_shr = mplr >> 1;
`ifdef SHIFT_MUL_EARLY_EXIT_EN
      last_iter = (cnt == CW'(WIDTH - 1)) || (mplr_shr == {WIDTH{1'b0}});
`else
      last_iter = (cnt == CW'(WIDTH - 1));
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            busy = 1'b1;
            if (last_iter) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            done = 1'b1;
            if (start) begin
               load      = 1'b1;
               state_nxt = S_RUN;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mcand   <= '0;
         mplr    <= '0;
         acc     <= '0;
         cnt     <= '0;
         product <= '0;
      end else if (load) begin
         mcand <= {{WIDTH{1'b0}}, a};
         mplr  <= b;
         acc   <= '0;
         cnt   <= '0;
      end else if (state == S_RUN) begin
         acc   <= acc_sum;
         mcand <= mcand << 1;
         mplr  <= mplr_shr;
         cnt   <= cnt + 1'b1;
         // product captures this edge's addition so it is valid with done
         if (last_iter) begin
            product <= acc_sum;
         end
      end
   end

endmodule
